// File: rtl/pwm_duty_controller.sv
`default_nettype none
// pwm_duty_controller: sequences the PWM duty word (off / soft-start ramp / hold / triangle sweep),
// updating duty only on PWM period boundaries. Rev 1.0
module pwm_duty_controller #(
   parameter int N              = 8,
   parameter int DEBOUNCE_TICKS = 12000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic [1:0]   buttons,
   input  logic         period_done,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [N-1:0] cmd_duty,
   input  logic [N-1:0] cmd_step,
   output logic [N-1:0] duty,
   output logic         pwm_ena,
   output logic         busy,
   output logic [1:0]   mode
);

   localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
   localparam logic [N:0] DUTY_MAX = {1'b0, {N{1'b1}}};

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_RAMP  = 2'd1,
      S_HOLD  = 2'd2,
      S_SWEEP = 2'd3
   } state_t;

   logic [1:0] press;

   for (genvar i = 0; i < 2; i++) begin : g_btn
      logic          sync1, sync2, level, pulse;
      logic [CW-1:0] cnt;

      // level only follows the synced input after DEBOUNCE_TICKS consecutive differing cycles
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            pulse <= 1'b0;
            cnt   <= '0;
         end else begin
            sync1 <= buttons[i];
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 == level) begin
               cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
               level <= sync2;
               pulse <= sync2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end

      assign press[i] = pulse;
   end

   state_t      state, state_nx;
   logic [N-1:0] duty_nx, target, target_nx, step, step_nx;
   logic         dir_down, dir_down_nx, shutdown, shutdown_nx;
   logic [N:0]   sum, dec;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_OFF;
         duty     <= '0;
         target   <= '0;
         step     <= N'(1);
         dir_down <= 1'b0;
         shutdown <= 1'b0;
      end else begin
         state    <= state_nx;
         duty     <= duty_nx;
         target   <= target_nx;
         step     <= step_nx;
         dir_down <= dir_down_nx;
         shutdown <= shutdown_nx;
      end
   end

   assign cmd_ready = ena && (state != S_RAMP);
   assign pwm_ena   = ena && (state != S_OFF);
   assign busy      = (state == S_RAMP);
   assign mode      = state;

   assign sum = {1'b0, duty} + {1'b0, step};
   assign dec = {1'b0, duty} - {1'b0, step};

   always_comb begin
      state_nx    = state;
      duty_nx     = duty;
      target_nx   = target;
      step_nx     = step;
      dir_down_nx = dir_down;
      shutdown_nx = shutdown;

      if (press[1]) begin
         state_nx    = S_OFF;
         duty_nx     = '0;
         shutdown_nx = 1'b0;
      end else if (ena) begin
         if (cmd_valid && cmd_ready) begin
            target_nx   = cmd_duty;
            step_nx     = (cmd_step == '0) ? N'(1) : cmd_step;
            shutdown_nx = 1'b0;
            state_nx    = (cmd_duty == duty) ? S_HOLD : S_RAMP;
         end else if (press[0] && state != S_RAMP) begin
            if (state == S_OFF) begin
               state_nx    = S_SWEEP;
               dir_down_nx = 1'b0;
            end else if (duty == '0) begin
               state_nx    = S_OFF;
               shutdown_nx = 1'b0;
            end else begin
               state_nx    = S_RAMP;
               target_nx   = '0;
               shutdown_nx = 1'b1;
            end
         end else if (period_done) begin
            case (state)
               S_RAMP: begin
                  // clamp at target; both differences are non-negative so no wrap is possible
                  if ((duty < target && (target - duty) <= step) ||
                      (duty > target && (duty - target) <= step) ||
                      (duty == target)) begin
                     duty_nx     = target;
                     state_nx    = shutdown ? S_OFF : S_HOLD;
                     shutdown_nx = 1'b0;
                  end else if (duty < target) begin
                     duty_nx = sum[N-1:0];
                  end else begin
                     duty_nx = dec[N-1:0];
                  end
               end
               S_SWEEP: begin
                  if (!dir_down) begin
                     if (sum >= DUTY_MAX) begin
                        duty_nx     = DUTY_MAX[N-1:0];
                        dir_down_nx = 1'b1;
                     end else begin
                        duty_nx = sum[N-1:0];
                     end
                  end else begin
                     if (step >= duty) begin
                        duty_nx     = '0;
                        dir_down_nx = 1'b0;
                     end else begin
                        duty_nx = dec[N-1:0];
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_controller.sv
`default_nettype none
// tb_pwm_duty_controller: directed self-checking bench for pwm_duty_controller (N=8, DEBOUNCE_TICKS=4).
module tb_pwm_duty_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [1:0] buttons;
   logic       period_done;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_duty;
   logic [7:0] cmd_step;
   logic [7:0] duty;
   logic       pwm_ena;
   logic       busy;
   logic [1:0] mode;

   int n_checks = 0;
   int n_fail   = 0;

   pwm_duty_controller #(.N(8), .DEBOUNCE_TICKS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .buttons     (buttons),
      .period_done (period_done),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_duty    (cmd_duty),
      .cmd_step    (cmd_step),
      .duty        (duty),
      .pwm_ena     (pwm_ena),
      .busy        (busy),
      .mode        (mode)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_pd();
      period_done = 1'b1;
      tick(1);
      period_done = 1'b0;
      tick(2);
   endtask

   task automatic send_cmd(input logic [7:0] d, input logic [7:0] s);
      cmd_duty  = d;
      cmd_step  = s;
      cmd_valid = 1'b1;
      tick(1);
      cmd_valid = 1'b0;
   endtask

   // press pulse appears 6 edges after the raw change and acts on the 7th
   task automatic press(input int idx);
      buttons[idx] = 1'b1;
      tick(7);
      buttons[idx] = 1'b0;
      tick(8);
   endtask

   initial begin
      logic [7:0] sweep_exp [7];
      sweep_exp = '{8'd100, 8'd200, 8'd255, 8'd155, 8'd55, 8'd0, 8'd100};

      rst = 1'b0; ena = 1'b1; buttons = 2'b00; period_done = 1'b0;
      cmd_valid = 1'b0; cmd_duty = '0; cmd_step = '0;
      tick(2);
      check("rst_mode", mode, 0);
      check("rst_duty", duty, 0);
      check("rst_pwm_ena", pwm_ena, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      rst = 1'b1;
      tick(1);

      // ramp 0 -> 10 in steps of 4
      send_cmd(8'd10, 8'd4);
      check("ramp_mode", mode, 1);
      check("ramp_busy", busy, 1);
      check("ramp_duty0", duty, 0);
      pulse_pd();
      check("ramp_duty1", duty, 4);
      tick(3);
      check("ramp_hold_between", duty, 4);
      pulse_pd();
      check("ramp_duty2", duty, 8);
      pulse_pd();
      check("ramp_duty3", duty, 10);
      check("ramp_end_mode", mode, 2);
      check("ramp_end_busy", busy, 0);

      // shutdown ramp from HOLD at 12, step 5
      send_cmd(8'd12, 8'd5);
      pulse_pd();
      check("sd_hold12", duty, 12);
      check("sd_hold_mode", mode, 2);
      press(0);
      check("sd_ramp_mode", mode, 1);
      pulse_pd();
      check("sd_duty7", duty, 7);
      pulse_pd();
      check("sd_duty2", duty, 2);
      pulse_pd();
      check("sd_duty0", duty, 0);
      check("sd_mode_off", mode, 0);
      check("sd_pwm_ena", pwm_ena, 0);

      // sweep with step 100
      send_cmd(8'd0, 8'd100);
      check("sw_hold_at0", mode, 2);
      press(0);
      check("sw_hold0_to_off", mode, 0);
      press(0);
      check("sw_mode", mode, 3);
      for (int k = 0; k < 7; k++) begin
         pulse_pd();
         check($sformatf("sw_duty%0d", k), duty, sweep_exp[k]);
      end
      press(1);
      check("sw_stop_mode", mode, 0);
      check("sw_stop_duty", duty, 0);

      // debounce: short glitch ignored, clean press gives one transition
      buttons[0] = 1'b1;
      tick(3);
      buttons[0] = 1'b0;
      tick(12);
      check("db_glitch", mode, 0);
      press(0);
      check("db_press", mode, 3);
      check("db_duty", duty, 0);
      tick(10);
      check("db_once", mode, 3);
      press(1);
      check("db_stop", mode, 0);

      // stop and cmd in the same cycle
      send_cmd(8'd50, 8'd200);
      pulse_pd();
      check("cf_hold50", duty, 50);
      buttons[1] = 1'b1;
      tick(6);
      cmd_duty = 8'd20; cmd_step = 8'd1; cmd_valid = 1'b1;
      check("cf_ready", cmd_ready, 1);
      tick(1);
      cmd_valid = 1'b0;
      check("cf_mode", mode, 0);
      check("cf_duty", duty, 0);
      buttons[1] = 1'b0;
      tick(8);
      check("cf_still_off", mode, 0);

      // stop during RAMP
      send_cmd(8'd100, 8'd10);
      pulse_pd();
      check("sr_duty10", duty, 10);
      buttons[1] = 1'b1;
      tick(6);
      check("sr_before", mode, 1);
      tick(1);
      check("sr_mode", mode, 0);
      check("sr_duty", duty, 0);
      buttons[1] = 1'b0;
      tick(8);

      // ena low freezes a ramp
      send_cmd(8'd40, 8'd10);
      pulse_pd();
      check("en_duty10", duty, 10);
      ena = 1'b0;
      #1;
      check("en_cmd_ready", cmd_ready, 0);
      check("en_pwm_ena", pwm_ena, 0);
      repeat (5) pulse_pd();
      check("en_frozen_duty", duty, 10);
      check("en_frozen_mode", mode, 1);
      ena = 1'b1;
      pulse_pd();
      check("en_resume20", duty, 20);
      pulse_pd();
      check("en_resume30", duty, 30);

      // asynchronous reset mid-ramp, between clock edges
      #2;
      rst = 1'b0;
      #1;
      check("ar_duty", duty, 0);
      check("ar_mode", mode, 0);
      check("ar_pwm_ena", pwm_ena, 0);
      tick(2);
      rst = 1'b1;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
